// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e : E-stage operation encoding driven on md_op_E
//   state_e : controller FSM states
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational 32x32 multiply / divide datapath.
//   op             : operation (mult/multu/div/divu produce a result)
//   a, b           : rs / rt operands
//   cur_hi, cur_lo : current architectural HI/LO, passed through on
//                    divide-by-zero and on non-arithmetic ops
//   res_hi, res_lo : product {hi,lo}, or {remainder, quotient}
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic        is_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);

    // Low 64 bits of an unsigned product of sign-extended operands equal
    // the signed product.
    a_ext = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod  = a_ext * b_ext;

    // Sign-magnitude divide: truncation toward zero falls out naturally, and
    // 0x80000000 / -1 yields magnitude 0x80000000 which negates to itself.
    a_mag  = (is_signed && a[31]) ? (32'd0 - a) : a;
    b_mag  = (is_signed && b[31]) ? (32'd0 - b) : b;
    b_safe = (b == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (is_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
    rem    = (is_signed && a[31]) ? (32'd0 - r_mag) : r_mag;

    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
      MD_DIV, MD_DIVU: begin
        if (b != '0) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller with architectural HI/LO.
//   clk, reset : clock, asynchronous active-high reset
//   md_op_E    : E-stage md operation (see md_op_e)
//   rs_val_E   : forwarded rs operand
//   rt_val_E   : forwarded rt operand
//   md_use_D   : D-stage instruction touches the md unit or HI/LO
//   busy       : unit occupied (state != IDLE)
//   start      : mult/div accepted this cycle
//   md_stall   : stall request to the hazard unit
//   hi, lo     : architectural HI/LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_val_E,
  input  logic [31:0] rt_val_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        start,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  md_op_e          op;
  state_e          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]     hi_q, hi_nxt;
  logic [31:0]     lo_q, lo_nxt;
  logic [31:0]     pend_hi, pend_hi_nxt;
  logic [31:0]     pend_lo, pend_lo_nxt;
  logic [31:0]     res_hi;
  logic [31:0]     res_lo;

  assign op = md_op_e'(md_op_E);

  mdu_arith u_arith (
    .op     (op),
    .a      (rs_val_E),
    .b      (rt_val_E),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = hi_q;
    lo_nxt      = lo_q;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    start       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        case (op)
          MD_MULT, MD_MULTU: begin
            start       = 1'b1;
            state_nxt   = ST_MUL;
            cnt_nxt     = CNT_W'(MULT_CYCLES - 1);
            pend_hi_nxt = res_hi;
            pend_lo_nxt = res_lo;
          end
          MD_DIV, MD_DIVU: begin
            start       = 1'b1;
            state_nxt   = ST_DIV;
            cnt_nxt     = CNT_W'(DIV_CYCLES - 1);
            pend_hi_nxt = res_hi;
            pend_lo_nxt = res_lo;
          end
          MD_MTHI: hi_nxt = rs_val_E;
          MD_MTLO: lo_nxt = rs_val_E;
          default: ;
        endcase
      end
      ST_MUL, ST_DIV: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign md_stall = md_use_D && (start || busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  md_op_E = '0;
  logic [31:0] rs_val_E = '0;
  logic [31:0] rt_val_E = '0;
  logic        md_use_D = 1'b0;
  logic        busy, start, md_stall;
  logic [31:0] hi, lo;

  int passes = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op_E  (md_op_E),
    .rs_val_E (rs_val_E),
    .rt_val_E (rt_val_E),
    .md_use_D (md_use_D),
    .busy     (busy),
    .start    (start),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 0) return {h, l};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {h, l};
    endcase
  endfunction

  task automatic model_edge(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [63:0] r;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (op >= 3'd1 && op <= 3'd4) begin
      r      = ref_res(op, rs, rt, m_hi, m_lo);
      m_phi  = r[63:32];
      m_plo  = r[31:0];
      m_left = (op <= 3'd2) ? MC : DC;
    end else if (op == 3'd5) begin
      m_hi = rs;
    end else if (op == 3'd6) begin
      m_lo = rs;
    end
  endtask

  task automatic step(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic use_d);
    logic exp_start;
    @(negedge clk);
    md_op_E  = op;
    rs_val_E = rs;
    rt_val_E = rt;
    md_use_D = use_d;
    #1;
    exp_start = (m_left == 0) && (op >= 3'd1) && (op <= 3'd4);
    chk("start", 32'(start), 32'(exp_start));
    chk("md_stall", 32'(md_stall), 32'(use_d && (exp_start || m_left != 0)));
    @(posedge clk);
    model_edge(op, rs, rt);
    #1;
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  task automatic idle(input int n, input logic use_d);
    for (int k = 0; k < n; k++) step(3'd0, $urandom, $urandom, use_d);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busy_cnt;
    logic [2:0] rop;

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mult -2 * 3 with D-stage user: stall from accept through busy window
    step(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    busy_cnt = 0;
    for (int k = 0; k < MC + 1; k++) begin
      step(3'd0, 32'd0, 32'd0, 1'b1);
      if (k < MC) busy_cnt++;
    end
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    step(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle(MC, 1'b0);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(DC, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    step(3'd4, 32'd7, 32'd2, 1'b0);
    idle(DC, 1'b0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // divide by zero keeps HI/LO
    step(3'd5, 32'h11, 32'd0, 1'b0);
    step(3'd6, 32'h22, 32'd0, 1'b0);
    step(3'd3, 32'd5, 32'd0, 1'b1);
    idle(DC, 1'b1);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DC, 1'b0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // mtlo while busy is ignored; in IDLE it lands next edge
    step(3'd1, 32'd6, 32'd7, 1'b0);
    step(3'd6, 32'h55, 32'd0, 1'b0);
    idle(MC - 1, 1'b0);
    chk("ign_lo", lo, 32'd42);
    step(3'd6, 32'h55, 32'd0, 1'b0);
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_busy", 32'(busy), 32'd0);

    // async reset mid-DIV with nonzero HI/LO
    step(3'd5, 32'hAA, 32'd0, 1'b0);
    step(3'd3, 32'd100, 32'd7, 1'b0);
    idle(5, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    m_hi = '0; m_lo = '0; m_left = 0; m_phi = '0; m_plo = '0;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(3'd1, 32'd9, 32'hFFFF_FFFF, 1'b1);
    idle(MC + 1, 1'b1);
    chk("post_hi", hi, 32'hFFFF_FFFF);
    chk("post_lo", lo, 32'hFFFF_FFF7);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 9) < 3 ? 0 : $urandom_range(1, 7));
      step(rop, pick(), pick(), 1'($urandom_range(0, 1)));
    end
    idle(DC + 1, 1'b0);

    chk("mult_busy_window", 32'(busy_cnt), 32'(MC));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller with architectural HI/LO registers for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds a busy window of fixed length.
- Raises md_stall toward the hazard unit so that any D-stage HI/LO-related instruction waits until the unit is free.
- mfhi/mflo read the hi/lo outputs combinationally through the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high.
- md_op_E  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_val_E  in  32  forwarded rs operand.
- rt_val_E  in  32  forwarded rt operand.
- md_use_D  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- busy  out  1  unit occupied.
- start  out  1  combinational: md_op_E in 1..4 and accepted this cycle.
- md_stall  out  1  combinational: md_use_D && (start || busy).
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (async, active-high): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pending regs=0.
- States are IDLE, MUL and DIV. busy is 1 exactly when state≠IDLE.
- Acceptance: an op is accepted only in IDLE. An op arriving while busy is ignored (no state, HI or LO change). The hazard unit guarantees this never occurs in legal flow; the bench still checks it.
- Mult/multu accepted at edge k:
  - Full 64-bit product is computed and latched into pending_hi/pending_lo.
  - Signed for mult, unsigned for multu.
  - State goes to MUL with cnt=MULT_CYCLES-1.
- Div/divu accepted at edge k:
  - Quotient is latched into pending_lo and remainder into pending_hi.
  - State goes to DIV with cnt=DIV_CYCLES-1.
- Signed divide rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: the unit still goes busy for DIV_CYCLES; pending regs are loaded from the current hi/lo, so HI/LO end unchanged.
- In MUL/DIV each edge does: if cnt≠0 then cnt−=1; else hi←pending_hi, lo←pending_lo, state←IDLE.
  - busy is therefore high for exactly N cycles after the accept edge.
  - HI/LO are visible on the edge that drops busy.
- mthi/mtlo in IDLE: hi (resp. lo) ← rs_val_E at that edge; busy stays 0.
- Read behaviour:
  - hi/lo never show pending values mid-operation; they show old values until commit.
  - On the commit cycle a D-stage mfhi is still stalled (busy=1). It is released the next cycle and then sees the new value.
- Reset mid-operation discards the operation: HI=LO=0, IDLE immediately.
- md_stall depends on start so that an md instruction directly behind an accepted mult in D is held from that same cycle.

Decomposition:
- Shared package/header holds the md_op encodings (MD_NONE..MD_MTLO) and the state encodings.
- One natural sub-module, mdu_arith: purely combinational 32×32 signed/unsigned multiply and divide with the divide-by-zero and overflow rules above, producing {res_hi, res_lo}.
- mdu_ctrl keeps the FSM, counter, pending regs and HI/LO.

Test Plan:
- Mult timing: mult rs=0xFFFFFFFE (−2), rt=3 → busy high for 5 cycles after the accept edge; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- Signed divide: div rs=−7 (0xFFFFFFF9), rt=2 → after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=2 → lo=3, hi=1.
- Boundary divides:
  - Divide by zero with hi=0x11, lo=0x22 preset via mthi/mtlo → busy 10 cycles, hi/lo unchanged.
  - 0x80000000 div 0xFFFFFFFF → lo=0x80000000, hi=0.
- Stall interaction: accept mult with md_use_D=1 → md_stall=1 from the accept cycle through all 5 busy cycles, 0 the following cycle; md_use_D=0 → md_stall=0 throughout.
- Ignored op: issue mtlo 0x55 while busy → lo ends equal to the mult result, not 0x55; mtlo 0x55 in IDLE → lo=0x55 next edge, busy stays 0.
- Reset during operation: reset asserted asynchronously mid-DIV (cnt=4) → busy, hi and lo drop to 0 without waiting for a clock edge; a mult issued after release completes normally.
